uart_frame_sequencer: RTL and testbench
=======================================

Name: uart_frame_sequencer

Overview:
- Sequences one captured scope frame out through the byte-wide UART transmitter.
- On a start pulse, reads N_SAMPLES bytes from the capture RAM.
- Wraps them as: SYNC0, SYNC1, length byte, samples, checksum.
- Feeds each byte to the transmitter using its enable/write handshake, and owns the transmitter exclusively while busy.

Parameters:
- N_SAMPLES, 256: samples per frame; legal range 1..2^ADDR_W.
- ADDR_W, 8: capture RAM address width.
- SYNC0, 8'hAA: first header byte.
- SYNC1, 8'h55: second header byte.
- ACK_TIMEOUT, 8: cycles to wait for the transmitter to drop write before re-issuing enable.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle request to send a frame
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the checksum byte's stop bit completes
- retry  out  1  one-cycle pulse each time an ack timeout re-issues enable
- mem_addr  out  ADDR_W  capture RAM read address
- mem_data  in  8  capture RAM read data; valid 1 cycle after mem_addr (synchronous read)
- tx_enable  out  1  request to the transmitter; one-cycle pulse per byte
- tx_data  out  8  byte to the transmitter; held stable for the whole byte
- tx_write  in  1  transmitter idle flag (1 = idle, 0 = shifting)

Behaviour:
- Reset (rst low at a clk edge), every output registered:
  - busy=0, done=0, retry=0, tx_enable=0.
  - tx_data=8'h00, mem_addr=0, checksum=0, byte index=0.
  - State IDLE.
  - Reset mid-frame aborts immediately. tx_enable is already 0, so at most the in-flight byte finishes on the line. No done pulse.
- Frame:
  - Total length N_SAMPLES+4 bytes.
  - Byte 2 (length byte) = (N_SAMPLES-1) mod 256.
  - Checksum = (length byte + all samples) mod 256, 8-bit wrap.
- States:
  - IDLE: when start=1 and tx_write=1, go to LOAD, set busy, clear byte index and checksum, set mem_addr=0. A start with tx_write=0, or while busy, is ignored.
  - LOAD: select the next byte:
    - index 0 -> SYNC0; index 1 -> SYNC1; index 2 -> length.
    - Sample indices: wait one extra cycle for RAM latency, then latch mem_data.
    - Last index -> checksum.
    - Latch the selected byte into tx_data, then go to SEND.
  - SEND: tx_enable=1 for exactly one cycle; load the timeout counter; go to WAIT_ACK.
  - WAIT_ACK: on tx_write=0, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT with tx_write still 1, pulse retry and go to SEND. tx_data is unchanged.
  - WAIT_DONE: on tx_write=1:
    - Add tx_data to checksum if the index is in 2..N_SAMPLES+2.
    - If the byte just sent was the last, go to FINISH.
    - Otherwise increment the index, advance mem_addr to the next sample, and go to LOAD.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
- tx_data changes only in LOAD. It never changes while tx_write=0.
- mem_addr:
  - Increments only after a sample byte completes.
  - Stays at N_SAMPLES-1 after the last sample; no wrap.
  - At N_SAMPLES=2^ADDR_W, the last address is all ones.
- start arriving in the same cycle as FINISH is ignored. A new frame needs start while in IDLE.
- Expected handshake with the transmitter: tx_write falls 2 cycles after the tx_enable pulse. ACK_TIMEOUT must be ≥3.

Test Plan:
- N_SAMPLES=4; RAM holds 10,20,30,40 (hex); transmitter model attached; pulse start -> tx_data sequence AA,55,03,10,20,30,40,A3. Exactly 8 tx_enable pulses, then done pulses once, then busy=0.
- RAM holds FF,FF,FF,FF (N=4) -> checksum byte = (03+3FC) mod 256 = FF; 8-bit wrap verified.
- Transmitter model ignores the first tx_enable -> retry pulses after 8 cycles, second tx_enable carries the same byte AA, frame completes normally.
- start pulsed again mid-frame and in the FINISH cycle -> no extra bytes, single done; start with tx_write=0 in IDLE -> ignored.
- rst low during sample byte 2 -> next cycle busy=0, tx_enable=0, mem_addr=0; subsequent start sends a complete, correct frame.
- tx_data sampled on every cycle with tx_write=0 -> never changes within a byte.

Source files
------------

// File: rtl/uart_frame_sequencer.sv
// Streams one capture frame (sync, length, samples, checksum) into the
// byte-wide UART transmitter using its enable/write handshake.
module uart_frame_sequencer #(
    parameter int         N_SAMPLES   = 256,
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SYNC0       = 8'hAA,
    parameter logic [7:0] SYNC1       = 8'h55,
    parameter int         ACK_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              retry,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              tx_enable,
    output logic [7:0]        tx_data,
    input  logic              tx_write
);

    localparam int IW = $clog2(N_SAMPLES + 4) + 1;
    localparam int CW = $clog2(ACK_TIMEOUT) + 1;

    localparam logic [IW-1:0] I_SY1  = IW'(1);
    localparam logic [IW-1:0] I_LEN  = IW'(2);
    localparam logic [IW-1:0] I_S0   = IW'(3);
    localparam logic [IW-1:0] I_SL   = IW'(N_SAMPLES + 2);
    localparam logic [IW-1:0] I_LAST = IW'(N_SAMPLES + 3);
    localparam logic [7:0]    LEN_B  = 8'((N_SAMPLES - 1) % 256);
    localparam logic [CW-1:0] TO_END = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    csum;
    logic [CW-1:0] cnt;
    logic          ram_wait;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            retry     <= 1'b0;
            tx_enable <= 1'b0;
            tx_data   <= 8'h00;
            mem_addr  <= '0;
            idx       <= '0;
            csum      <= 8'h00;
            cnt       <= '0;
            ram_wait  <= 1'b0;
        end else begin
            tx_enable <= 1'b0;
            done      <= 1'b0;
            retry     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && tx_write) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        idx      <= '0;
                        csum     <= 8'h00;
                        mem_addr <= '0;
                        ram_wait <= 1'b0;
                    end
                end
                LOAD: begin
                    unique case (1'b1)
                        (idx == '0): begin
                            tx_data <= SYNC0;
                            state   <= SEND;
                        end
                        (idx == I_SY1): begin
                            tx_data <= SYNC1;
                            state   <= SEND;
                        end
                        (idx == I_LEN): begin
                            tx_data <= LEN_B;
                            state   <= SEND;
                        end
                        (idx == I_LAST): begin
                            tx_data <= csum;
                            state   <= SEND;
                        end
                        default: begin
                            // first cycle covers the synchronous RAM latency
                            if (!ram_wait) begin
                                ram_wait <= 1'b1;
                            end else begin
                                ram_wait <= 1'b0;
                                tx_data  <= mem_data;
                                state    <= SEND;
                            end
                        end
                    endcase
                end
                SEND: begin
                    tx_enable <= 1'b1;
                    cnt       <= '0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!tx_write) begin
                        state <= WAIT_DONE;
                    end else if (cnt == TO_END) begin
                        retry <= 1'b1;
                        state <= SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_write) begin
                        if (idx >= I_LEN && idx <= I_SL)
                            csum <= csum + tx_data;
                        if (idx == I_LAST) begin
                            state <= FINISH;
                        end else begin
                            idx <= idx + 1'b1;
                            // hold the last sample address; never wrap
                            if (idx >= I_S0 && idx < I_SL)
                                mem_addr <= mem_addr + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboard bench: expected frame bytes queued at stimulus time and
// popped on each accepted transmitter enable.
module tb_uart_frame_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, retry, tx_enable, tx_write;
    logic [7:0] mem_addr, mem_data, tx_data;
    logic [7:0] ram [256];

    logic txw_int = 1'b1;
    logic hold_low = 1'b0;
    assign tx_write = txw_int & ~hold_low;

    uart_frame_sequencer #(
        .N_SAMPLES  (N),
        .ADDR_W     (8),
        .SYNC0      (8'hAA),
        .SYNC1      (8'h55),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .retry    (retry),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .tx_enable(tx_enable),
        .tx_data  (tx_data),
        .tx_write (tx_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= ram[mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q [$];

    int dly = 0, shf = 0, ign = 0;
    int n_en = 0, n_done = 0, n_retry = 0;
    int cyc = 0, ign_cyc = 0, ret_cyc = 0;
    logic       track = 1'b0;
    logic [7:0] cur = 8'h00;

    // transmitter model plus done/retry monitor
    always @(negedge clk) begin
        cyc++;
        if (done) n_done++;
        if (retry) begin
            n_retry++;
            ret_cyc = cyc;
        end
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                txw_int = 1'b0;
                shf = 6;
            end
        end else if (shf > 0) begin
            shf--;
            if (shf == 0) begin
                txw_int = 1'b1;
                track = 1'b0;
            end
        end
        if (track && !txw_int)
            chk("tx_data_stable", tx_data, cur);
        if (tx_enable && rst) begin
            if (ign > 0) begin
                ign--;
                ign_cyc = cyc;
                chk("ignored_byte", tx_data, 8'hAA);
            end else begin
                n_en++;
                cur = tx_data;
                track = 1'b1;
                dly = 1;
                if (exp_q.size() == 0)
                    chk("extra_byte", exp_q.size(), 1);
                else
                    chk("tx_byte", tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic load_frame(input logic [7:0] a, b, c, d);
        logic [7:0] s;
        ram[0] = a; ram[1] = b; ram[2] = c; ram[3] = d;
        s = 8'(N - 1) + a + b + c + d;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'(N - 1));
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(s);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk(tag, 0, 1);
    endtask

    task automatic wait_en(input int n, input string tag);
        int k = 0;
        while (n_en < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk(tag, n_en, n);
    endtask

    task automatic run_frame(input string tag);
        n_en = 0;
        n_done = 0;
        pulse_start();
        chk({tag, "_busy"}, busy, 1);
        wait_done({tag, "_timeout"});
        repeat (3) @(negedge clk);
        chk({tag, "_enables"}, n_en, N + 4);
        chk({tag, "_dones"}, n_done, 1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_retry", retry, 0);
        chk("rst_en", tx_enable, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        load_frame(8'h10, 8'h20, 8'h30, 8'h40);
        run_frame("basic");

        load_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_frame("wrap");

        ign = 1;
        n_retry = 0;
        load_frame(8'h10, 8'h20, 8'h30, 8'h40);
        run_frame("retry");
        chk("retry_count", n_retry, 1);
        chk("retry_gap", ret_cyc - ign_cyc, 8);

        n_en = 0;
        n_done = 0;
        load_frame(8'h5A, 8'h01, 8'h80, 8'h7F);
        pulse_start();
        wait_en(3, "mid_en_timeout");
        start = 1'b1;
        wait_done("mid_timeout");
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_enables", n_en, N + 4);
        chk("mid_dones", n_done, 1);
        chk("mid_idle", busy, 0);
        chk("mid_q_empty", exp_q.size(), 0);

        hold_low = 1'b1;
        n_en = 0;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("txlow_busy", busy, 0);
        chk("txlow_enables", n_en, 0);
        hold_low = 1'b0;
        repeat (2) @(negedge clk);

        n_en = 0;
        n_done = 0;
        load_frame(8'h10, 8'h20, 8'h30, 8'h40);
        pulse_start();
        wait_en(5, "rst_en_timeout");
        @(negedge clk);
        rst = 1'b0;
        track = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_en", tx_enable, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_data", tx_data, 0);
        @(negedge clk) rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_dones", n_done, 0);
        exp_q.delete();
        load_frame(8'h01, 8'h02, 8'h03, 8'h04);
        run_frame("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
